// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - word-organised instruction memory with boot image, load port and fetch error flag
module instruction_memory #(
    parameter int unsigned ADDR_WORDS_LOG2 = 8,
    parameter logic [31:0] BASE_ADDR       = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    output logic [31:0] Data,
    output logic        Misaligned,
    output logic        OutOfRange,
    output logic        FetchErr,
    input  logic        LoadEn,
    input  logic [31:0] LoadAddr,
    input  logic [31:0] LoadData
);
    localparam int unsigned WORDS = 1 << ADDR_WORDS_LOG2;
    localparam int unsigned TOP   = ADDR_WORDS_LOG2 + 2;

    logic [31:0] mem_q [WORDS];
    logic        fetch_err_q, fetch_err_d;

    logic [32:0] fetch_off, load_off;
    logic        fetch_oor, load_oor, load_ok;
    logic [ADDR_WORDS_LOG2-1:0] fetch_idx, load_idx;

    function automatic logic [31:0] boot_word(input int unsigned idx);
        case (idx)
            0:       return 32'h20080005;
            1:       return 32'h20090003;
            2:       return 32'h01095020;
            3:       return 32'hAC0A0000;
            4:       return 32'h08000004;
            default: return 32'h00000000;
        endcase
    endfunction

    // 33-bit subtraction: bit 32 is the borrow for addresses below BASE_ADDR.
    assign fetch_off = {1'b0, Addr} - {1'b0, BASE_ADDR};
    assign load_off  = {1'b0, LoadAddr} - {1'b0, BASE_ADDR};

    assign fetch_oor = fetch_off[32] | (|fetch_off[31:TOP]);
    assign load_oor  = load_off[32]  | (|load_off[31:TOP]);
    assign fetch_idx = fetch_off[TOP-1:2];
    assign load_idx  = load_off[TOP-1:2];

    assign Misaligned = |fetch_off[1:0];
    assign OutOfRange = fetch_oor;
    assign Data       = (Misaligned | fetch_oor) ? 32'h00000000 : mem_q[fetch_idx];
    assign load_ok    = LoadEn & ~(|load_off[1:0]) & ~load_oor;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                mem_q[i] <= boot_word(i);
            end
        end else if (load_ok) begin
            mem_q[load_idx] <= LoadData;
        end
    end

    always_comb begin
        fetch_err_d = fetch_err_q;
        if (Misaligned | fetch_oor) begin
            fetch_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_err_q <= 1'b0;
        end else begin
            fetch_err_q <= fetch_err_d;
        end
    end

    assign FetchErr = fetch_err_q;
endmodule

// File: tb/tb_instruction_memory.sv
// tb/tb_instruction_memory.sv - self-checking bench for instruction_memory
module tb_instruction_memory;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Addr;
    logic [31:0] Data;
    logic        Misaligned;
    logic        OutOfRange;
    logic        FetchErr;
    logic        LoadEn;
    logic [31:0] LoadAddr;
    logic [31:0] LoadData;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        mis;
        logic        oor;
    } vec_t;

    vec_t exp_q[$];
    vec_t boot_tbl[7];

    instruction_memory dut (
        .clk(clk),
        .reset(reset),
        .Addr(Addr),
        .Data(Data),
        .Misaligned(Misaligned),
        .OutOfRange(OutOfRange),
        .FetchErr(FetchErr),
        .LoadEn(LoadEn),
        .LoadAddr(LoadAddr),
        .LoadData(LoadData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive Addr and push the expected response; the DUT answers combinationally.
    task automatic drive_read(input logic [31:0] a, input logic [31:0] d, input logic m, input logic o);
        vec_t v;
        v.addr = a; v.data = d; v.mis = m; v.oor = o;
        Addr = a;
        exp_q.push_back(v);
    endtask

    task automatic check_read(input string name);
        vec_t v;
        #1;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            v = exp_q.pop_front();
            chk({name, ".data"}, Data, v.data);
            chk({name, ".mis"}, {31'b0, Misaligned}, {31'b0, v.mis});
            chk({name, ".oor"}, {31'b0, OutOfRange}, {31'b0, v.oor});
        end
    endtask

    task automatic read(input string name, input logic [31:0] a, input logic [31:0] d,
                        input logic m, input logic o);
        drive_read(a, d, m, o);
        check_read(name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        boot_tbl[0] = '{32'd0,    32'h20080005, 1'b0, 1'b0};
        boot_tbl[1] = '{32'd4,    32'h20090003, 1'b0, 1'b0};
        boot_tbl[2] = '{32'd8,    32'h01095020, 1'b0, 1'b0};
        boot_tbl[3] = '{32'd12,   32'hAC0A0000, 1'b0, 1'b0};
        boot_tbl[4] = '{32'd16,   32'h08000004, 1'b0, 1'b0};
        boot_tbl[5] = '{32'd20,   32'h00000000, 1'b0, 1'b0};
        boot_tbl[6] = '{32'd1020, 32'h00000000, 1'b0, 1'b0};

        reset = 1'b1; Addr = 32'd0; LoadEn = 1'b0; LoadAddr = 32'd0; LoadData = 32'd0;
        #2;
        chk("reset_fetcherr", {31'b0, FetchErr}, 32'd0);
        read("reset_word0", 32'd0, 32'h20080005, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        foreach (boot_tbl[i]) begin
            @(negedge clk);
            read($sformatf("boot[%0d]", i), boot_tbl[i].addr, boot_tbl[i].data, boot_tbl[i].mis, boot_tbl[i].oor);
        end
        @(negedge clk);
        chk("boot_fetcherr", {31'b0, FetchErr}, 32'd0);

        // Collision: old word before the edge, new word right after it.
        @(negedge clk);
        LoadEn = 1'b1; LoadAddr = 32'd8; LoadData = 32'hDEADBEEF;
        read("collide_before", 32'd8, 32'h01095020, 1'b0, 1'b0);
        @(posedge clk);
        check_read_after_edge: begin
            drive_read(32'd8, 32'hDEADBEEF, 1'b0, 1'b0);
            check_read("collide_after");
        end
        @(negedge clk);
        LoadAddr = 32'd1020; LoadData = 32'h12345678;
        @(negedge clk);
        LoadEn = 1'b0;
        read("load_last", 32'd1020, 32'h12345678, 1'b0, 1'b0);

        // Dropped loads: out of range (would alias word 0) and misaligned (would hit word 1).
        @(negedge clk);
        LoadEn = 1'b1; LoadAddr = 32'd1024; LoadData = 32'hBAD0BAD0;
        @(negedge clk);
        LoadAddr = 32'd6; LoadData = 32'hBAD1BAD1;
        @(negedge clk);
        LoadEn = 1'b0;
        read("drop_oor", 32'd0, 32'h20080005, 1'b0, 1'b0);
        read("drop_mis", 32'd4, 32'h20090003, 1'b0, 1'b0);
        @(negedge clk);
        chk("drop_no_err", {31'b0, FetchErr}, 32'd0);

        // Misaligned fetch makes FetchErr stick.
        @(negedge clk);
        read("mis_fetch", 32'd2, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("mis_err_set", {31'b0, FetchErr}, 32'd1);
        read("back_to_0", 32'd0, 32'h20080005, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("err_sticky", {31'b0, FetchErr}, 32'd1);

        // Asynchronous reset mid-cycle restores the image and clears the flag at once.
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_err_clr", {31'b0, FetchErr}, 32'd0);
        read("async_word2", 32'd8, 32'h01095020, 1'b0, 1'b0);
        read("async_last", 32'd1020, 32'h0, 1'b0, 1'b0);

        // Reset wins over a load at the same edge.
        LoadEn = 1'b1; LoadAddr = 32'd0; LoadData = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        LoadEn = 1'b0;
        reset = 1'b0;
        read("reset_wins", 32'd0, 32'h20080005, 1'b0, 1'b0);

        // Out of range above the window.
        @(negedge clk);
        read("oor_1024", 32'd1024, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        chk("oor_1024_err", {31'b0, FetchErr}, 32'd1);

        // Wrap-around address.
        do_reset();
        read("oor_wrap_clean", 32'd0, 32'h20080005, 1'b0, 1'b0);
        @(negedge clk);
        chk("wrap_pre_err", {31'b0, FetchErr}, 32'd0);
        read("oor_wrap", 32'hFFFFFFFC, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        chk("oor_wrap_err", {31'b0, FetchErr}, 32'd1);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
